tipi_nibble_xchg: RTL and testbench

Parametrised successor to the TIPI TI<->RPi register exchange. It replaces the fixed 2x2 shift registers (RC/RD/TC/TD) with NCH channel pairs of DW-bit registers, moved over the RPi nibble bus with an XOR check nibble.
All logic runs on one system clock. The asynchronous RPi strobes (r_clk, r_nibrst) are synchronised internally.
The TI decode logic drives the strobed TI-side port. The RPi GPIO pins drive the r_* ports.

---
 rtl/tipi_nibble_xchg.sv | 182 ++++++++++++++++++
 tb/tb_tipi_nibble_xchg.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tipi_nibble_xchg.sv
// tipi_nibble_xchg: exchanges registers between the TI and the RPi. There are NCH
// channel pairs of DW-bit registers. They move over a NW-bit nibble bus, and each
// frame ends with an XOR check nibble.
// Ports: clk/reset (sync, active-high); r_clk, r_nibrst, r_nib_in are async RPi pins
// (internally synced); r_nib_out/r_nib_oe drive the RPi nibble bus; ti_wr_* / ti_rd_*
// form the strobed TI side; to_pi_new/from_pi_new are the per-channel handshake flags;
// err_cnt counts write frames rejected by the check nibble (saturating).
module tipi_nibble_xchg #(
  parameter int NCH = 2,
  parameter int DW  = 8,
  parameter int NW  = 4,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r_clk,
  input  logic          r_nibrst,
  input  logic [NW-1:0] r_nib_in,
  output logic [NW-1:0] r_nib_out,
  output logic          r_nib_oe,
  input  logic          ti_wr_stb,
  input  logic [CW-1:0] ti_wr_ch,
  input  logic [DW-1:0] ti_wr_data,
  input  logic          ti_rd_stb,
  input  logic [CW-1:0] ti_rd_ch,
  output logic [DW-1:0] ti_rd_data,
  output logic [NCH-1:0] to_pi_new,
  output logic [NCH-1:0] from_pi_new,
  output logic [7:0]    err_cnt
);

  localparam int NNIB = DW / NW;
  localparam int CNTW = $clog2(NNIB) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WDATA = 3'd1;
  localparam logic [2:0] WCHK  = 3'd2;
  localparam logic [2:0] RDATA = 3'd3;
  localparam logic [2:0] RCHK  = 3'd4;

  // Two-flop synchronisers. clk_s3 delays the synced strobe by one more cycle
  // so that its rising edge can be detected.
  logic          clk_s1, clk_s2, clk_s3;
  logic          rst_s1, rst_s2;
  logic [NW-1:0] nib_s1, nib_s2;

  logic [2:0]      state;
  logic [CNTW-1:0] cnt;
  logic [NW-1:0]   xacc;     // running XOR of the header and data nibbles
  logic [DW-1:0]   shadow;   // write-frame assembly register
  logic [DW-1:0]   osr;      // read-frame output shift register (snapshot)
  logic [CW-1:0]   hdr_ch;
  logic            hdr_ok;

  logic [DW-1:0]   to_pi   [NCH];
  logic [DW-1:0]   from_pi [NCH];

  logic          nstb;
  logic [CW-1:0] new_ch;
  logic          new_ok;
  logic          wr_ok;
  logic          rd_ok;

  // A frame reset masks strobes, so a strobe that arrives together with it is dropped.
  assign nstb = clk_s2 & ~clk_s3 & ~rst_s2;

  // Out-of-range channels wrap modulo the next power of two (low CW bits). Any
  // channel that is still >= NCH after the wrap is flagged as invalid.
  assign new_ch = nib_s2[CW-1:0];
  assign new_ok = (int'(new_ch) < NCH);
  assign wr_ok  = (int'(ti_wr_ch) < NCH);
  assign rd_ok  = (int'(ti_rd_ch) < NCH);

  assign ti_rd_data = rd_ok ? from_pi[ti_rd_ch] : '0;

  assign r_nib_oe = (state == RDATA) || (state == RCHK);

  always_comb begin
    r_nib_out = '0;
    if (state == RDATA) r_nib_out = osr[DW-1 -: NW];
    else if (state == RCHK) r_nib_out = xacc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1      <= 1'b0;
      clk_s2      <= 1'b0;
      clk_s3      <= 1'b0;
      rst_s1      <= 1'b0;
      rst_s2      <= 1'b0;
      nib_s1      <= '0;
      nib_s2      <= '0;
      state       <= IDLE;
      cnt         <= '0;
      xacc        <= '0;
      shadow      <= '0;
      osr         <= '0;
      hdr_ch      <= '0;
      hdr_ok      <= 1'b0;
      to_pi_new   <= '0;
      from_pi_new <= '0;
      err_cnt     <= '0;
      for (int i = 0; i < NCH; i++) begin
        to_pi[i]   <= '0;
        from_pi[i] <= '0;
      end
    end else begin
      clk_s1 <= r_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      rst_s1 <= r_nibrst;
      rst_s2 <= rst_s1;
      nib_s1 <= r_nib_in;
      nib_s2 <= nib_s1;

      // The TI acknowledge is applied first. A commit later in this block, on the
      // same channel, overrides it.
      if (ti_rd_stb && rd_ok) from_pi_new[ti_rd_ch] <= 1'b0;

      if (rst_s2) begin
        state  <= IDLE;
        cnt    <= '0;
        xacc   <= '0;
        shadow <= '0;
      end else if (nstb) begin
        case (state)
          IDLE: begin
            hdr_ch <= new_ch;
            hdr_ok <= new_ok;
            xacc   <= nib_s2;
            cnt    <= '0;
            shadow <= '0;
            if (nib_s2[NW-1]) begin
              osr   <= new_ok ? to_pi[new_ch] : '0;
              state <= RDATA;
            end else begin
              state <= WDATA;
            end
          end
          WDATA: begin
            shadow <= (shadow << NW) | DW'(nib_s2);
            xacc   <= xacc ^ nib_s2;
            cnt    <= cnt + CNTW'(1);
            if (cnt == CNTW'(NNIB - 1)) state <= WCHK;
          end
          WCHK: begin
            if (nib_s2 == xacc) begin
              if (hdr_ok) begin
                from_pi[hdr_ch]     <= shadow;
                from_pi_new[hdr_ch] <= 1'b1;
              end
            end else if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            cnt   <= '0;
            state <= IDLE;
          end
          RDATA: begin
            xacc <= xacc ^ osr[DW-1 -: NW];
            osr  <= osr << NW;
            cnt  <= cnt + CNTW'(1);
            if (cnt == CNTW'(NNIB - 1)) state <= RCHK;
          end
          RCHK: begin
            if (hdr_ok) to_pi_new[hdr_ch] <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // A TI write is applied after the read-complete clear, so a write to the
      // same channel in the same cycle leaves the flag set.
      if (ti_wr_stb && wr_ok) begin
        to_pi[ti_wr_ch]     <= ti_wr_data;
        to_pi_new[ti_wr_ch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tipi_nibble_xchg.sv
// Testbench for tipi_nibble_xchg: directed frames on a NCH=2/DW=8 instance and a
// NCH=4/DW=16 instance. Expected values go into queues; monitors compare them.
module tb_tipi_nibble_xchg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       r_clk, r_nibrst;
  logic [3:0] r_nib_in;

  // instance A: NCH=2, DW=8
  logic [3:0] out_a;
  logic       oe_a;
  logic       wr_stb_a, rd_stb_a;
  logic [0:0] wr_ch_a, rd_ch_a;
  logic [7:0] wr_data_a, rd_data_a, err_a;
  logic [1:0] tnew_a, fnew_a;

  // instance B: NCH=4, DW=16
  logic [3:0]  out_b;
  logic        oe_b;
  logic        wr_stb_b, rd_stb_b;
  logic [1:0]  wr_ch_b, rd_ch_b;
  logic [15:0] wr_data_b, rd_data_b;
  logic [7:0]  err_b;
  logic [3:0]  tnew_b, fnew_b;

  tipi_nibble_xchg #(.NCH(2), .DW(8), .NW(4)) dut_a (
    .clk(clk), .reset(rst_a), .r_clk(r_clk), .r_nibrst(r_nibrst), .r_nib_in(r_nib_in),
    .r_nib_out(out_a), .r_nib_oe(oe_a),
    .ti_wr_stb(wr_stb_a), .ti_wr_ch(wr_ch_a), .ti_wr_data(wr_data_a),
    .ti_rd_stb(rd_stb_a), .ti_rd_ch(rd_ch_a), .ti_rd_data(rd_data_a),
    .to_pi_new(tnew_a), .from_pi_new(fnew_a), .err_cnt(err_a)
  );

  tipi_nibble_xchg #(.NCH(4), .DW(16), .NW(4)) dut_b (
    .clk(clk), .reset(rst_b), .r_clk(r_clk), .r_nibrst(r_nibrst), .r_nib_in(r_nib_in),
    .r_nib_out(out_b), .r_nib_oe(oe_b),
    .ti_wr_stb(wr_stb_b), .ti_wr_ch(wr_ch_b), .ti_wr_data(wr_data_b),
    .ti_rd_stb(rd_stb_b), .ti_rd_ch(rd_ch_b), .ti_rd_data(rd_data_b),
    .to_pi_new(tnew_b), .from_pi_new(fnew_b), .err_cnt(err_b)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t       chk_q[$];
  logic [3:0] nib_q[$];
  int         errors = 0;
  int         checks = 0;
  int         mon_sel = 0;   // which instance the nibble monitor watches

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0:  return 32'(tnew_a);
      1:  return 32'(fnew_a);
      2:  return 32'(err_a);
      3:  return 32'(rd_data_a);
      4:  return 32'(oe_a);
      5:  return 32'(out_a);
      10: return 32'(tnew_b);
      11: return 32'(fnew_b);
      12: return 32'(err_b);
      13: return 32'(rd_data_b);
      14: return 32'(oe_b);
      15: return 32'(out_b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Level-check monitor: on every falling edge it pops and compares all queued entries.
  always @(negedge clk) begin : level_mon
    chk_t c;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      cmp(c.name, actual(c.sel), c.exp);
    end
  end

  // Nibble monitor: the RPi samples the bus at each strobe while the block drives it.
  always @(posedge r_clk) begin : nib_mon
    logic [3:0] e;
    if ((mon_sel == 0) ? oe_a : oe_b) begin
      if (nib_q.size() == 0) begin
        cmp("nib_unexpected", 32'((mon_sel == 0) ? out_a : out_b), 32'hFFFF_FFFF);
      end else begin
        e = nib_q.pop_front();
        cmp("nib", 32'((mon_sel == 0) ? out_a : out_b), 32'(e));
      end
    end
  end

  task automatic expect_v(int sel, logic [31:0] exp, string name);
    chk_q.push_back('{sel: sel, exp: exp, name: name});
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(logic [3:0] n);
    @(posedge clk); #1;
    r_nib_in = n;
    r_clk    = 1'b1;
    repeat (5) @(posedge clk);
    #1 r_clk = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  // Strobe with a TI event placed in the clock where the synced strobe takes effect.
  // kind 0: TI read ack of ch1 on instance A; kind 1: TI write 0x22 to ch0 on instance A.
  task automatic strobe_ev(logic [3:0] n, int kind);
    @(posedge clk); #1;
    r_nib_in = n;
    r_clk    = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    if (kind == 0) begin rd_ch_a = 1'b1; rd_stb_a = 1'b1; end
    else begin wr_ch_a = 1'b0; wr_data_a = 8'h22; wr_stb_a = 1'b1; end
    @(posedge clk); #1;
    rd_stb_a = 1'b0;
    wr_stb_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 r_clk = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic frame4(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    strobe(a); strobe(b); strobe(c); strobe(d);
  endtask

  task automatic ti_write_a(logic [0:0] ch, logic [7:0] d);
    @(posedge clk); #1;
    wr_ch_a = ch; wr_data_a = d; wr_stb_a = 1'b1;
    @(posedge clk); #1;
    wr_stb_a = 1'b0;
  endtask

  task automatic ti_write_b(logic [1:0] ch, logic [15:0] d);
    @(posedge clk); #1;
    wr_ch_b = ch; wr_data_b = d; wr_stb_b = 1'b1;
    @(posedge clk); #1;
    wr_stb_b = 1'b0;
  endtask

  task automatic ti_ack_a(logic [0:0] ch);
    @(posedge clk); #1;
    rd_ch_a = ch; rd_stb_a = 1'b1;
    @(posedge clk); #1;
    rd_stb_a = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    r_clk = 1'b0; r_nibrst = 1'b0; r_nib_in = 4'h0;
    wr_stb_a = 1'b0; rd_stb_a = 1'b0; wr_ch_a = '0; rd_ch_a = '0; wr_data_a = '0;
    wr_stb_b = 1'b0; rd_stb_b = 1'b0; wr_ch_b = '0; rd_ch_b = '0; wr_data_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    repeat (2) @(posedge clk);

    // reset state of instance A
    expect_v(0, 0, "rst_to_pi_new");
    expect_v(1, 0, "rst_from_pi_new");
    expect_v(2, 0, "rst_err_cnt");
    expect_v(3, 0, "rst_ti_rd_data");
    expect_v(4, 0, "rst_oe");
    expect_v(5, 0, "rst_nib_out");

    // RPi read of ch1 holding 0xA5: A, 5, check 9^A^5 = 6
    ti_write_a(1'b1, 8'hA5);
    expect_v(0, 32'h2, "rd_to_pi_new_before");
    nib_q.push_back(4'hA); nib_q.push_back(4'h5); nib_q.push_back(4'h6);
    frame4(4'h9, 4'h0, 4'h0, 4'h0);
    expect_v(0, 32'h0, "rd_to_pi_new_after");
    expect_v(4, 0, "rd_oe_after");

    // RPi write ch0 = 0x3C, check 0^3^C = F
    rd_ch_a = 1'b0;
    frame4(4'h0, 4'h3, 4'hC, 4'hF);
    expect_v(1, 32'h1, "wr_from_pi_new");
    expect_v(3, 32'h3C, "wr_data");
    ti_ack_a(1'b0);
    expect_v(1, 32'h0, "wr_ack_clears");

    // bad check nibble: discarded, counted
    frame4(4'h0, 4'h3, 4'hC, 4'hE);
    expect_v(3, 32'h3C, "bad_data_kept");
    expect_v(2, 32'h1, "bad_err_cnt");
    expect_v(1, 32'h0, "bad_no_flag");

    // frame reset after one data nibble, then a good frame ch1 = 0x5A (check 1^5^A = E)
    strobe(4'h0); strobe(4'h7);
    @(posedge clk); #1 r_nibrst = 1'b1;
    repeat (6) @(posedge clk);
    #1 r_nibrst = 1'b0;
    repeat (6) @(posedge clk);
    expect_v(1, 32'h0, "nibrst_no_commit");
    expect_v(2, 32'h1, "nibrst_err_same");
    frame4(4'h1, 4'h5, 4'hA, 4'hE);
    rd_ch_a = 1'b1;
    expect_v(1, 32'h2, "after_nibrst_flag");
    expect_v(3, 32'h5A, "after_nibrst_data");
    expect_v(2, 32'h1, "after_nibrst_err");

    // commit and TI ack on ch1 in the same clock: commit wins (check 1^7^7 = 1)
    strobe(4'h1); strobe(4'h7); strobe(4'h7);
    strobe_ev(4'h1, 0);
    expect_v(1, 32'h2, "commit_vs_ack_flag");
    expect_v(3, 32'h77, "commit_vs_ack_data");
    ti_ack_a(1'b1);
    expect_v(1, 32'h0, "ack_after_commit");

    // read-check strobe and TI write on ch0 in the same clock (check 8^1^1 = 8)
    ti_write_a(1'b0, 8'h11);
    expect_v(0, 32'h1, "rchk_pre_flag");
    nib_q.push_back(4'h1); nib_q.push_back(4'h1); nib_q.push_back(4'h8);
    strobe(4'h8); strobe(4'h0); strobe(4'h0);
    strobe_ev(4'h0, 1);
    expect_v(0, 32'h1, "rchk_vs_write_flag");
    nib_q.push_back(4'h2); nib_q.push_back(4'h2); nib_q.push_back(4'h8);
    frame4(4'h8, 4'h0, 4'h0, 4'h0);
    expect_v(0, 32'h0, "rchk_new_data_read");

    // 299 more bad frames, 300 in total: the count saturates at 255
    for (int i = 0; i < 299; i++) frame4(4'h0, 4'h3, 4'hC, 4'hE);
    expect_v(2, 32'hFF, "err_saturate");

    // instance B: NCH=4, DW=16
    mon_sel = 1;
    @(posedge clk); #1 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    expect_v(10, 0, "b_rst_to_pi_new");
    expect_v(14, 0, "b_rst_oe");
    ti_write_b(2'd3, 16'h1234);
    expect_v(10, 32'h8, "b_to_pi_new_ch3");
    // header F -> channel 7 wraps to 3; check F^1^2^3^4 = B
    nib_q.push_back(4'h1); nib_q.push_back(4'h2); nib_q.push_back(4'h3);
    nib_q.push_back(4'h4); nib_q.push_back(4'hB);
    strobe(4'hF); strobe(4'h0); strobe(4'h0); strobe(4'h0); strobe(4'h0); strobe(4'h0);
    expect_v(10, 32'h0, "b_to_pi_new_after");
    expect_v(14, 0, "b_oe_after");
    // write ch0 = 0xCAFE, check 0^C^A^F^E = 7; then the same frame with a bad check
    rd_ch_b = 2'd0;
    strobe(4'h0); strobe(4'hC); strobe(4'hA); strobe(4'hF); strobe(4'hE); strobe(4'h7);
    expect_v(11, 32'h1, "b_wr_flag");
    expect_v(13, 32'hCAFE, "b_wr_data");
    strobe(4'h0); strobe(4'hC); strobe(4'hA); strobe(4'hF); strobe(4'hE); strobe(4'h0);
    expect_v(12, 32'h1, "b_err_cnt");
    // start reading ch2 and then reset mid-frame
    ti_write_b(2'd2, 16'hBEEF);
    strobe(4'hA);
    expect_v(14, 32'h1, "b_mid_oe");
    expect_v(15, 32'hB, "b_mid_nib");
    expect_v(10, 32'h4, "b_mid_to_pi_new");
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    expect_v(14, 0, "b_rst2_oe");
    expect_v(15, 0, "b_rst2_nib");
    expect_v(10, 0, "b_rst2_to_pi_new");
    expect_v(11, 0, "b_rst2_from_pi_new");
    expect_v(12, 0, "b_rst2_err");
    expect_v(13, 0, "b_rst2_rd_data");

    repeat (2) @(negedge clk);
    cmp("nib_queue_drained", 32'(nib_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
